// File: rtl/mem_burst_writer.sv
// ---------------------------------------------------------------------------
// mem_burst_writer
//
// Purpose:
//   Takes a burst command (base address + length) and a valid/ready data
//   stream, and turns each accepted data word into one write on the write
//   port of an inferred embedded RAM. Addresses advance sequentially from the
//   base address and wrap modulo the RAM depth. The RAM enable is only high
//   on cycles that actually carry a write, so the memory stays idle the rest
//   of the time.
//
// Parameters:
//   ADDR_W - RAM address width (depth = 2**ADDR_W)
//   DATA_W - RAM data width
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   rst        : synchronous active-high reset
//   cmd_valid  : burst command valid
//   cmd_ready  : writer can accept a command (IDLE, not in reset)
//   cmd_addr   : burst base address
//   cmd_len    : burst length in words (0 allowed)
//   s_valid    : write data valid
//   s_ready    : writer accepts data (WRITE, not in reset)
//   s_data     : write data word
//   mem_en     : RAM enable (registered)
//   mem_we     : RAM write enable (registered)
//   mem_addr   : RAM address (registered)
//   mem_din    : RAM write data (registered)
//   busy       : high while a burst is in progress (WRITE or DONE)
//   done       : one-cycle pulse at burst completion
// ---------------------------------------------------------------------------
module mem_burst_writer #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W + 1)'(1);

    state_t              state_q;
    logic [ADDR_W-1:0]   cur_addr_q;
    logic [ADDR_W-1:0]   cur_addr_d;
    logic [ADDR_W:0]     remaining_q;
    logic [ADDR_W:0]     remaining_d;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_din_q;
    logic                done_q;
    logic                beat;

    // Handshake readies come straight from the state register; they are
    // forced low while reset is asserted so nothing is accepted on that edge.
    assign cmd_ready = ~rst & (state_q == ST_IDLE);
    assign s_ready   = ~rst & (state_q == ST_WRITE);
    assign beat      = s_valid & s_ready;

    // Address wraps naturally through the ADDR_W-bit adder.
    assign cur_addr_d  = cur_addr_q + ADDR_W'(1);
    assign remaining_d = remaining_q - LEN_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            // Enable/write-enable and done are single-cycle by default;
            // mem_addr/mem_din hold their last values between writes.
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_addr_q  <= cmd_addr;
                        remaining_q <= cmd_len;
                        if (cmd_len == '0) begin
                            // Empty burst: go straight to completion.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WRITE;
                        end
                    end
                end

                ST_WRITE: begin
                    if (beat) begin
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= cur_addr_q;
                        mem_din_q   <= s_data;
                        cur_addr_q  <= cur_addr_d;
                        remaining_q <= remaining_d;
                        if (remaining_q == LEN_ONE) begin
                            // done is registered on the same edge as the
                            // final write so both appear together.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en   = mem_en_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign done     = done_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_burst_writer.sv
// ---------------------------------------------------------------------------
// tb_mem_burst_writer
//
// Self-checking bench for mem_burst_writer. A behavioural model tracks where
// each accepted word must land ((base + k) mod depth) and the expected RAM
// image; a monitor builds the image the DUT actually writes. Directed
// scenarios are followed by randomized bursts.
// ---------------------------------------------------------------------------
module tb_mem_burst_writer;

    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          busy;
    logic          done;

    int checks      = 0;
    int errors      = 0;
    int cycle_cnt   = 0;
    int last_accept = 0;

    logic [DW-1:0] model_ram  [DEPTH];
    logic [DW-1:0] shadow_ram [DEPTH];
    bit            wflag      [DEPTH];

    // Expected held values of mem_addr/mem_din between writes.
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_din;

    // Optional directed stimulus; random values are used when empty.
    bit            vpat [$];
    logic [DW-1:0] dq   [$];

    always #5 clk = ~clk;

    mem_burst_writer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done)
    );

    // RAM-side monitor: acts as the embedded RAM and checks enable pairing.
    always @(negedge clk) begin
        checks++;
        if (mem_en !== mem_we) begin
            errors++;
            $display("FAIL en_we_pair: mem_en=%b mem_we=%b (must be equal)", mem_en, mem_we);
        end
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            shadow_ram[mem_addr] = mem_din;
            wflag[mem_addr]      = 1'b1;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_cnt++;
    endtask

    // Generic burst driver with per-cycle expectations from the model.
    task automatic burst(input logic [AW-1:0] addr, input logic [AW:0] len, input int vprob,
                         input bit hold_cmd, input logic [AW-1:0] nxt_addr, input logic [AW:0] nxt_len);
        int            k;
        int            guard;
        bit            v;
        logic [DW-1:0] d;
        logic [AW-1:0] exp_a;
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_len   = len;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL cmd_ready_idle: got %b expected 1", cmd_ready); end
        tick();
        last_accept = cycle_cnt;
        if (hold_cmd) begin
            cmd_addr = nxt_addr;
            cmd_len  = nxt_len;
        end else begin
            cmd_valid = 1'b0;
        end
        if (len == '0) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy: got %b expected 1", busy); end
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL zero_cmd_ready: got %b expected 0", cmd_ready); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL zero_we: got %b expected 0", mem_we); end
            tick();
        end else begin
            k     = 0;
            guard = 0;
            while (k < int'(len) && guard < 500) begin
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL s_ready_write: got %b expected 1", s_ready); end
                checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL cmd_ready_write: got %b expected 0", cmd_ready); end
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_write: got %b expected 1", busy); end
                v = (vpat.size() > 0) ? vpat.pop_front() : ($urandom_range(99) < vprob);
                d = (dq.size() > 0) ? dq[0] : DW'($urandom);
                if (v && dq.size() > 0) void'(dq.pop_front());
                s_valid = v;
                s_data  = d;
                tick();
                checks++; if (mem_we !== v) begin errors++; $display("FAIL mem_we_beat: got %b expected %b (k=%0d)", mem_we, v, k); end
                checks++; if (mem_en !== v) begin errors++; $display("FAIL mem_en_beat: got %b expected %b (k=%0d)", mem_en, v, k); end
                if (v) begin
                    exp_a = addr + AW'(k);
                    checks++; if (mem_addr !== exp_a) begin errors++; $display("FAIL mem_addr: got %0d expected %0d (k=%0d)", mem_addr, exp_a, k); end
                    checks++; if (mem_din !== d) begin errors++; $display("FAIL mem_din: got %h expected %h (k=%0d)", mem_din, d, k); end
                    model_ram[exp_a] = d;
                    hold_addr = exp_a;
                    hold_din  = d;
                    k++;
                end else begin
                    checks++; if (mem_addr !== hold_addr) begin errors++; $display("FAIL addr_hold: got %0d expected %0d", mem_addr, hold_addr); end
                    checks++; if (mem_din !== hold_din) begin errors++; $display("FAIL din_hold: got %h expected %h", mem_din, hold_din); end
                end
                checks++; if (done !== (k == int'(len))) begin errors++; $display("FAIL done_timing: got %b expected %b (k=%0d)", done, (k == int'(len)), k); end
                guard++;
            end
            checks++; if (k != int'(len)) begin errors++; $display("FAIL burst_timeout: wrote %0d words expected %0d", k, len); end
            s_valid = 1'b0;
            tick();
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en: got %b expected 0", mem_en); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b expected 0", cmd_ready); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b expected 0", s_ready); end
        tick();
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b expected 0", mem_en); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %0d expected 0", mem_addr); end
        checks++; if (mem_din !== '0) begin errors++; $display("FAIL rst_mem_din: got %h expected 0", mem_din); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready: got %b expected 1", cmd_ready); end
        hold_addr = '0;
        hold_din  = '0;
        $display("reset: done");
    endtask

    task automatic test_basic();
        dq = '{16'hA001, 16'hA002, 16'hA003};
        burst(3'd2, 4'd3, 100, 1'b0, '0, '0);
        $display("basic: addr=2 len=3 done");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH; i++) wflag[i] = 1'b0;
        dq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        burst(3'd6, 4'd4, 100, 1'b0, '0, '0);
        @(negedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (wflag[i] !== (i == 6 || i == 7 || i == 0 || i == 1)) begin
                errors++;
                $display("FAIL wrap_flags: addr %0d written=%b expected %b", i, wflag[i], (i == 6 || i == 7 || i == 0 || i == 1));
            end
        end
        $display("wrap: addr=6 len=4 done");
    endtask

    task automatic test_backpressure();
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
        burst(3'd4, 4'd2, 100, 1'b0, '0, '0);
        $display("backpressure: len=2 pattern 1001 done");
    endtask

    task automatic test_zero_len();
        burst(3'd3, 4'd0, 100, 1'b0, '0, '0);
        $display("zero_len: done");
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        d0 = DW'($urandom);
        d1 = DW'($urandom);
        cmd_valid = 1'b1; cmd_addr = 3'd1; cmd_len = 4'd5;
        tick();
        cmd_valid = 1'b0;
        s_valid = 1'b1; s_data = d0;
        tick();
        s_data = d1;
        tick();
        checks++; if (mem_we !== 1'b1 || mem_addr !== 3'd2 || mem_din !== d1) begin errors++; $display("FAIL mid_second_write: we=%b addr=%0d din=%h expected 1/2/%h", mem_we, mem_addr, mem_din, d1); end
        model_ram[1] = d0;
        model_ram[2] = d1;
        s_data = DW'($urandom);
        rst = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_s_ready: got %b expected 0", s_ready); end
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, done, busy} !== 4'b0) begin errors++; $display("FAIL mid_rst_flags: en/we/done/busy=%b expected 0000", {mem_en, mem_we, done, busy}); end
        checks++; if (mem_addr !== '0 || mem_din !== '0) begin errors++; $display("FAIL mid_rst_bus: addr=%0d din=%h expected 0/0", mem_addr, mem_din); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_cmd_ready: got %b expected 1", cmd_ready); end
        hold_addr = '0;
        hold_din  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (done !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet: done=%b mem_en=%b expected 0/0", done, mem_en); end
        end
        burst(3'd0, 4'd1, 100, 1'b0, '0, '0);
        $display("reset_mid: aborted after 2 writes, new burst ok");
    endtask

    task automatic test_cmd_during_burst();
        int t0;
        burst(3'd3, 4'd2, 100, 1'b1, 3'd5, 4'd1);
        t0 = last_accept;
        burst(3'd5, 4'd1, 100, 1'b0, '0, '0);
        checks++; if (last_accept - t0 !== 4) begin errors++; $display("FAIL cmd_spacing: got %0d cycles expected 4", last_accept - t0); end
        $display("cmd_during_burst: second accept after %0d cycles", last_accept - t0);
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [AW:0]   l;
        for (int n = 0; n < 25; n++) begin
            a = AW'($urandom_range(DEPTH - 1));
            l = (AW + 1)'($urandom_range((1 << (AW + 1)) - 1));
            burst(a, l, 60, 1'b0, '0, '0);
            $display("random[%0d]: addr=%0d len=%0d done", n, a, l);
        end
    endtask

    task automatic test_ram_image();
        @(negedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (shadow_ram[i] !== model_ram[i]) begin
                errors++;
                $display("FAIL ram_image: addr %0d got %h expected %h", i, shadow_ram[i], model_ram[i]);
            end
        end
        $display("ram_image: compared %0d words", DEPTH);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0;
        hold_addr = '0; hold_din = '0;
        for (int i = 0; i < DEPTH; i++) begin
            model_ram[i]  = '0;
            shadow_ram[i] = '0;
            wflag[i]      = 1'b0;
        end
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_reset_mid();
        test_cmd_during_burst();
        test_random();
        test_ram_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
